// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback queue.
package wb_pkg;

  localparam int WB_ADDR_W = 3;
  localparam int WB_DATA_W = 32;

  // Register 0 is hardwired; writes to it are accepted and dropped.
  localparam int unsigned WB_ZERO_REG = 0;

  // One queued write: destination register and its data.
  // The field is named wreg because "reg" is a reserved word.
  typedef struct packed {
    logic [WB_ADDR_W-1:0] wreg;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_match.sv
// Per-read-port hazard detector for the writeback queue.
// busy is set when any occupied entry targets read_reg (register 0 never matches).
// With WB_FORWARD_EN, also returns data of the youngest matching entry.
module wb_match
  import wb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = WB_ADDR_W
`ifdef WB_FORWARD_EN
  ,
  parameter int DATA_W = WB_DATA_W,
  parameter int PTR_W  = $clog2(DEPTH)
`endif
) (
  input  logic [ADDR_W-1:0] entry_reg [DEPTH],
`ifdef WB_FORWARD_EN
  input  logic [DATA_W-1:0] entry_data [DEPTH],
  input  logic [PTR_W-1:0]  rd_ptr,
  output logic [DATA_W-1:0] fwd_data,
`endif
  input  logic [DEPTH-1:0]  occupied,
  input  logic [ADDR_W-1:0] read_reg,
  output logic              busy
);

  logic             read_nonzero;
  logic [DEPTH-1:0] match;

  assign read_nonzero = (read_reg != ADDR_W'(WB_ZERO_REG));

  // Per-entry comparison, qualified by occupancy and a nonzero read address.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
    assign match[gi] = occupied[gi] && read_nonzero && (entry_reg[gi] == read_reg);
  end

  assign busy = |match;

`ifdef WB_FORWARD_EN
  // Walk from oldest (rd_ptr) to youngest; the last hit is the newest value.
  always_comb begin
    logic [PTR_W-1:0] idx;
    fwd_data = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PTR_W'(k);
      if (match[idx]) fwd_data = entry_data[idx];
    end
  end
`endif

endmodule

// File: rtl/writeback_queue.sv
// Writeback queue: buffers ALU / load results and drains one per cycle into
// the register-file write port. Load path has fixed priority over ALU.
// Optional forwarding of queued data is compiled in with WB_FORWARD_EN.
module writeback_queue
  import wb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [ADDR_W-1:0]        mem_reg,
  input  logic [DATA_W-1:0]        mem_data,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [ADDR_W-1:0]        alu_reg,
  input  logic [DATA_W-1:0]        alu_data,
  output logic                     RegWrite,
  output logic [ADDR_W-1:0]        write_reg,
  output logic [DATA_W-1:0]        write_data,
  input  logic [ADDR_W-1:0]        read_reg1,
  input  logic [ADDR_W-1:0]        read_reg2,
  output logic                     busy1,
  output logic                     busy2,
`ifdef WB_FORWARD_EN
  output logic [DATA_W-1:0]        fwd_data1,
  output logic [DATA_W-1:0]        fwd_data2,
`endif
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic [ADDR_W-1:0] ent_reg_mem  [DEPTH];
  logic [DATA_W-1:0] ent_data_mem [DEPTH];
  logic [DEPTH-1:0]  occupied;

  logic              full, mem_hs, alu_hs, push_en, pop_en;
  logic [ADDR_W-1:0] push_reg;
  logic [DATA_W-1:0] push_data;

  // Room is judged from registered occupancy only; a same-cycle pop does not count.
  assign full      = (count_reg == CNT_W'(DEPTH));
  assign mem_ready = !full;
  assign alu_ready = !full && !mem_valid;

  assign mem_hs    = mem_valid && mem_ready;
  assign alu_hs    = alu_valid && alu_ready;
  assign push_reg  = mem_hs ? mem_reg  : alu_reg;
  assign push_data = mem_hs ? mem_data : alu_data;
  // Handshakes to register 0 complete but are not stored.
  assign push_en   = (mem_hs || alu_hs) && (push_reg != ADDR_W'(WB_ZERO_REG));
  // The register file always accepts, so a non-empty head drains every cycle.
  assign pop_en    = (count_reg != '0);

  // Pointer and occupancy update for push / pop / both.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push_en) wr_ptr_next = wr_ptr_reg + 1'b1;
    if (pop_en)  rd_ptr_next = rd_ptr_reg + 1'b1;
    if (push_en && !pop_en)      count_next = count_reg + 1'b1;
    else if (!push_en && pop_en) count_next = count_reg - 1'b1;
  end

  // Queue control state; reset flushes all pending writes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Entry storage, not reset: occupancy alone qualifies contents.
  always_ff @(posedge clock) begin
    if (push_en) begin
      ent_reg_mem[wr_ptr_reg]  <= push_reg;
      ent_data_mem[wr_ptr_reg] <= push_data;
    end
  end

  // Entry gi is occupied when its age behind rd_ptr is below count.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_occ
    logic [PTR_W-1:0] age;
    assign age          = PTR_W'(gi) - rd_ptr_reg;
    assign occupied[gi] = (CNT_W'(age) < count_reg);
  end

  assign RegWrite   = pop_en;
  assign write_reg  = pop_en ? ent_reg_mem[rd_ptr_reg]  : '0;
  assign write_data = pop_en ? ent_data_mem[rd_ptr_reg] : '0;
  assign count      = count_reg;

  wb_match #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
`ifdef WB_FORWARD_EN
    , .DATA_W(DATA_W), .PTR_W(PTR_W)
`endif
  ) u_match1 (
    .entry_reg (ent_reg_mem),
`ifdef WB_FORWARD_EN
    .entry_data(ent_data_mem),
    .rd_ptr    (rd_ptr_reg),
    .fwd_data  (fwd_data1),
`endif
    .occupied  (occupied),
    .read_reg  (read_reg1),
    .busy      (busy1)
  );

  wb_match #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
`ifdef WB_FORWARD_EN
    , .DATA_W(DATA_W), .PTR_W(PTR_W)
`endif
  ) u_match2 (
    .entry_reg (ent_reg_mem),
`ifdef WB_FORWARD_EN
    .entry_data(ent_data_mem),
    .rd_ptr    (rd_ptr_reg),
    .fwd_data  (fwd_data2),
`endif
    .occupied  (occupied),
    .read_reg  (read_reg2),
    .busy      (busy2)
  );

endmodule
